// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares one L2 port between the L1 I-cache (read-only) and the L1 D-cache
// (read/write). The winning request is latched at grant and the L2 is driven
// only from that latched copy, so the L2 request stays stable until l2_resp
// even if the requester changes or drops its request. The D-cache has
// priority. A saturating starvation counter forces an I-cache grant after
// STARVE_LIMIT consecutive D grants that were taken while I was waiting.
module cache_arbiter #(
   parameter int unsigned ADDR_W       = 32,
   parameter int unsigned LINE_W       = 256,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   // I-cache side
   input  logic              i_cache_read,
   input  logic [ADDR_W-1:0] i_cache_address,
   output logic [LINE_W-1:0] i_cache_rdata,
   output logic              i_cache_resp,
   // D-cache side
   input  logic              d_cache_read,
   input  logic              d_cache_write,
   input  logic [ADDR_W-1:0] d_cache_address,
   input  logic [LINE_W-1:0] d_cache_wdata,
   output logic [LINE_W-1:0] d_cache_rdata,
   output logic              d_cache_resp,
   // L2 side
   output logic              l2_read,
   output logic              l2_write,
   output logic [ADDR_W-1:0] l2_address,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic [LINE_W-1:0] l2_rdata,
   input  logic              l2_resp
);

   // Counter is 4 bits wide because the limit is bounded to 1..15.
   localparam logic [3:0] STARVE_LIMIT_C = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t              state_r;
   state_t              state_nxt_s;
   logic [3:0]          starve_cnt_r;
   logic [3:0]          starve_cnt_nxt_s;
   logic                op_write_r;
   logic [ADDR_W-1:0]   addr_r;
   logic [LINE_W-1:0]   wdata_r;
   logic                d_req_s;
   logic                i_req_s;
   logic                grant_d_s;
   logic                grant_i_s;

   // Next starvation count for one grant decision. Only D grants taken while
   // I is waiting advance the count; any other grant clears it.
   function automatic logic [3:0] starve_next(
      input logic [3:0] cnt,
      input logic       grant_d,
      input logic       grant_i,
      input logic       i_pending
   );
      logic [3:0] res;
      res = cnt;
      if (grant_d && i_pending) begin
         if (cnt < STARVE_LIMIT_C) begin
            res = cnt + 4'd1;
         end else begin
            res = STARVE_LIMIT_C;
         end
      end else if (grant_d || grant_i) begin
         res = 4'd0;
      end else begin
         res = cnt;
      end
      return res;
   endfunction

   // Request decode; a simultaneous D read and write is treated as a write.
   always_comb begin
      d_req_s = d_cache_read | d_cache_write;
      i_req_s = i_cache_read;
   end

   // Next-state logic and grant decision.
   always_comb begin
      state_nxt_s = state_r;
      grant_d_s   = 1'b0;
      grant_i_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (d_req_s && (!i_req_s || (starve_cnt_r < STARVE_LIMIT_C))) begin
               state_nxt_s = GRANT_D;
               grant_d_s   = 1'b1;
            end else if (i_req_s) begin
               state_nxt_s = GRANT_I;
               grant_i_s   = 1'b1;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         GRANT_I, GRANT_D: begin
            if (l2_resp) begin
               state_nxt_s = DONE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         DONE: begin
            // One quiet cycle so the L1 can retire its request before IDLE
            // looks at it again.
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Starvation counter next value, evaluated only on grant cycles.
   always_comb begin
      starve_cnt_nxt_s = starve_next(starve_cnt_r, grant_d_s, grant_i_s, i_req_s);
   end

   // State and starvation counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r      <= IDLE;
         starve_cnt_r <= 4'd0;
      end else begin
         state_r      <= state_nxt_s;
         starve_cnt_r <= starve_cnt_nxt_s;
      end
   end

   // Capture the winning request at the grant edge; held until the next grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_write_r <= 1'b0;
         addr_r     <= {ADDR_W{1'b0}};
         wdata_r    <= {LINE_W{1'b0}};
      end else if (grant_d_s) begin
         op_write_r <= d_cache_write;
         addr_r     <= d_cache_address;
         wdata_r    <= d_cache_wdata;
      end else if (grant_i_s) begin
         // I-cache is read-only; the write line is left as it was.
         op_write_r <= 1'b0;
         addr_r     <= i_cache_address;
         wdata_r    <= wdata_r;
      end else begin
         op_write_r <= op_write_r;
         addr_r     <= addr_r;
         wdata_r    <= wdata_r;
      end
   end

   // L2 request strobes and per-requester response routing.
   always_comb begin
      l2_read      = 1'b0;
      l2_write     = 1'b0;
      i_cache_resp = 1'b0;
      d_cache_resp = 1'b0;
      case (state_r)
         GRANT_I: begin
            l2_read      = ~op_write_r;
            l2_write     = op_write_r;
            i_cache_resp = l2_resp;
         end
         GRANT_D: begin
            l2_read      = ~op_write_r;
            l2_write     = op_write_r;
            d_cache_resp = l2_resp;
         end
         IDLE, DONE: begin
            // A response arriving here belongs to nobody and is dropped.
            l2_read      = 1'b0;
            l2_write     = 1'b0;
            i_cache_resp = 1'b0;
            d_cache_resp = 1'b0;
         end
         default: begin
            l2_read      = 1'b0;
            l2_write     = 1'b0;
            i_cache_resp = 1'b0;
            d_cache_resp = 1'b0;
         end
      endcase
   end

   // Address/data always come from the latches; read data is broadcast and
   // qualified only by the per-requester resp.
   assign l2_address    = addr_r;
   assign l2_wdata      = wdata_r;
   assign i_cache_rdata = l2_rdata;
   assign d_cache_rdata = l2_rdata;

endmodule
